// File: rtl/round_start_if.sv
// round_start_if: qualifier, control and status bundle between the status logic and round_start_ctrl
// master drives the qualifiers and controls; slave is the controller side
interface round_start_if #(
   parameter int N_REQ   = 2,
   parameter int DELAY_W = 4,
   parameter int CNT_W   = 8
);
   logic [N_REQ-1:0]   req;
   logic [N_REQ-1:0]   req_mask;
   logic [DELAY_W-1:0] delay_cycles;
   logic               ack;
   logic               abort;
   logic               flag;
   logic               busy;
   logic [CNT_W-1:0]   round_cnt;
   modport master (
      output req, req_mask, delay_cycles, ack, abort,
      input  flag, busy, round_cnt
   );
   modport slave (
      input  req, req_mask, delay_cycles, ack, abort,
      output flag, busy, round_cnt
   );
endinterface

// File: rtl/round_start_ctrl.sv
// round_start_ctrl: fires a round-start flag once all enabled qualifiers are high and a countdown expires
// flag is a one-cycle pulse or a level held until ack; qualifiers must drop before the next round can start
module round_start_ctrl #(
   parameter int N_REQ      = 2,
   parameter int DELAY_W    = 4,
   parameter int CNT_W      = 8,
   parameter bit PULSE_MODE = 1'b1,
   parameter bit RESET_FLAG = 1'b1
) (
   input  logic          clk,
   input  logic          reset,
   round_start_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, COUNT, FIRE, HOLD} state_t;
   state_t             state, state_n;
   logic [DELAY_W-1:0] cnt, cnt_n;
   logic [CNT_W-1:0]   rounds, rounds_n;
   logic               flag_q, flag_n;
   logic [N_REQ-1:0]   req, mask;
   logic               qual;
   assign req  = bus.req;
   assign mask = bus.req_mask;
   // an all-zero mask must never qualify
   assign qual = (|mask) && (&(req | ~mask));
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         rounds <= '0;
         flag_q <= RESET_FLAG;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         rounds <= rounds_n;
         flag_q <= flag_n;
      end
   end
   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      rounds_n = rounds;
      flag_n   = flag_q;
      if (bus.abort) begin
         state_n = IDLE;
         cnt_n   = '0;
         flag_n  = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               flag_n = qual && (bus.delay_cycles == '0);
               if (qual && bus.delay_cycles == '0) begin
                  rounds_n = rounds + 1'b1;
                  state_n  = FIRE;
               end else if (qual) begin
                  cnt_n   = bus.delay_cycles;
                  state_n = COUNT;
               end
            end
            COUNT: begin
               flag_n = 1'b0;
               if (!qual) begin
                  state_n = IDLE;
               end else if (cnt > 1) begin
                  cnt_n = cnt - 1'b1;
               end else begin
                  flag_n   = 1'b1;
                  rounds_n = rounds + 1'b1;
                  state_n  = FIRE;
               end
            end
            FIRE: begin
               if (PULSE_MODE || bus.ack) begin
                  flag_n  = 1'b0;
                  state_n = HOLD;
               end
            end
            default: begin
               flag_n  = 1'b0;
               state_n = qual ? HOLD : IDLE;
            end
         endcase
      end
   end
   assign bus.flag      = flag_q;
   assign bus.busy      = state != IDLE;
   assign bus.round_cnt = rounds;
endmodule

// File: tb/tb_round_start_ctrl.sv
// tb_round_start_ctrl: directed vectors for pulse, level and narrow-counter variants of round_start_ctrl
module tb_round_start_ctrl;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   passed = 0;
   int   total = 0;
   always #5 clk = ~clk;
   round_start_if #(.N_REQ(2), .DELAY_W(4), .CNT_W(8)) ifp ();
   round_start_if #(.N_REQ(2), .DELAY_W(4), .CNT_W(8)) ifl ();
   round_start_if #(.N_REQ(2), .DELAY_W(4), .CNT_W(2)) ifw ();
   round_start_ctrl #(.N_REQ(2), .DELAY_W(4), .CNT_W(8), .PULSE_MODE(1'b1), .RESET_FLAG(1'b1))
      dut_p (.clk(clk), .reset(reset), .bus(ifp));
   round_start_ctrl #(.N_REQ(2), .DELAY_W(4), .CNT_W(8), .PULSE_MODE(1'b0), .RESET_FLAG(1'b1))
      dut_l (.clk(clk), .reset(reset), .bus(ifl));
   round_start_ctrl #(.N_REQ(2), .DELAY_W(4), .CNT_W(2), .PULSE_MODE(1'b1), .RESET_FLAG(1'b1))
      dut_w (.clk(clk), .reset(reset), .bus(ifw));
   typedef struct {
      logic       rst;
      logic [1:0] req;
      logic [1:0] mask;
      logic [3:0] dly;
      logic       ack;
      logic       abort;
      logic       fl;
      logic       bz;
      logic [7:0] rc;
   } vec_t;
   vec_t vecs[$];
   function automatic vec_t mk(logic rst, logic [1:0] req, logic [1:0] mask, logic [3:0] dly,
                               logic ack, logic abort, logic fl, logic bz, logic [7:0] rc);
      vec_t v;
      v.rst = rst; v.req = req; v.mask = mask; v.dly = dly; v.ack = ack; v.abort = abort;
      v.fl = fl; v.bz = bz; v.rc = rc;
      return v;
   endfunction
   task automatic drive(logic rst, logic [1:0] req, logic [1:0] mask, logic [3:0] dly,
                        logic ack, logic abort);
      reset = rst;
      ifp.req = req; ifp.req_mask = mask; ifp.delay_cycles = dly; ifp.ack = ack; ifp.abort = abort;
      ifl.req = req; ifl.req_mask = mask; ifl.delay_cycles = dly; ifl.ack = ack; ifl.abort = abort;
      ifw.req = req; ifw.req_mask = mask; ifw.delay_cycles = dly; ifw.ack = ack; ifw.abort = abort;
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      else passed++;
   endtask
   initial begin
      drive(1, 2'b00, 2'b11, 4'd0, 0, 0);
      // reset and zero-delay pulse
      vecs.push_back(mk(1, 2'b00, 2'b11, 0, 0, 0, 1, 0, 0));
      vecs.push_back(mk(1, 2'b00, 2'b11, 0, 0, 0, 1, 0, 0));
      vecs.push_back(mk(1, 2'b00, 2'b11, 0, 0, 0, 1, 0, 0));
      vecs.push_back(mk(0, 2'b00, 2'b11, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 2'b11, 2'b11, 0, 0, 0, 1, 1, 1));
      for (int i = 0; i < 10; i++) vecs.push_back(mk(0, 2'b11, 2'b11, 0, 0, 0, 0, 1, 1));
      vecs.push_back(mk(0, 2'b00, 2'b11, 0, 0, 0, 0, 0, 1));
      vecs.push_back(mk(0, 2'b11, 2'b11, 0, 0, 0, 1, 1, 2));
      vecs.push_back(mk(0, 2'b11, 2'b11, 0, 0, 0, 0, 1, 2));
      vecs.push_back(mk(0, 2'b00, 2'b11, 0, 0, 0, 0, 0, 2));
      // countdown of 5: flag on the 5th edge after leaving IDLE
      vecs.push_back(mk(0, 2'b11, 2'b11, 5, 0, 0, 0, 1, 2));
      for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 2'b11, 2'b11, 9, 0, 0, 0, 1, 2));
      vecs.push_back(mk(0, 2'b11, 2'b11, 9, 0, 0, 1, 1, 3));
      vecs.push_back(mk(0, 2'b11, 2'b11, 5, 0, 0, 0, 1, 3));
      vecs.push_back(mk(0, 2'b00, 2'b11, 5, 0, 0, 0, 0, 3));
      // cancelled countdown
      vecs.push_back(mk(0, 2'b11, 2'b11, 5, 0, 0, 0, 1, 3));
      vecs.push_back(mk(0, 2'b11, 2'b11, 5, 0, 0, 0, 1, 3));
      vecs.push_back(mk(0, 2'b11, 2'b11, 5, 0, 0, 0, 1, 3));
      vecs.push_back(mk(0, 2'b01, 2'b11, 5, 0, 0, 0, 0, 3));
      vecs.push_back(mk(0, 2'b00, 2'b11, 5, 0, 0, 0, 0, 3));
      // abort in COUNT, requalify without lockout, reset beats abort
      vecs.push_back(mk(0, 2'b11, 2'b11, 5, 0, 0, 0, 1, 3));
      vecs.push_back(mk(0, 2'b11, 2'b11, 5, 0, 1, 0, 0, 3));
      vecs.push_back(mk(0, 2'b11, 2'b11, 5, 0, 0, 0, 1, 3));
      vecs.push_back(mk(0, 2'b11, 2'b11, 5, 0, 1, 0, 0, 3));
      vecs.push_back(mk(0, 2'b00, 2'b11, 5, 0, 0, 0, 0, 3));
      vecs.push_back(mk(1, 2'b11, 2'b11, 0, 0, 1, 1, 0, 0));
      vecs.push_back(mk(0, 2'b00, 2'b11, 0, 0, 0, 0, 0, 0));
      // masks and ack ignored in pulse mode
      vecs.push_back(mk(0, 2'b01, 2'b01, 0, 0, 0, 1, 1, 1));
      vecs.push_back(mk(0, 2'b01, 2'b01, 0, 0, 0, 0, 1, 1));
      vecs.push_back(mk(0, 2'b00, 2'b01, 0, 0, 0, 0, 0, 1));
      vecs.push_back(mk(0, 2'b10, 2'b01, 0, 0, 0, 0, 0, 1));
      vecs.push_back(mk(0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 1));
      vecs.push_back(mk(0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 1));
      vecs.push_back(mk(0, 2'b11, 2'b11, 0, 1, 0, 1, 1, 2));
      vecs.push_back(mk(0, 2'b11, 2'b11, 0, 1, 0, 0, 1, 2));
      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].req, vecs[i].mask, vecs[i].dly, vecs[i].ack, vecs[i].abort);
         tick();
         chk($sformatf("v%0d flag", i), 32'(ifp.flag), 32'(vecs[i].fl));
         chk($sformatf("v%0d busy", i), 32'(ifp.busy), 32'(vecs[i].bz));
         chk($sformatf("v%0d round_cnt", i), 32'(ifp.round_cnt), 32'(vecs[i].rc));
      end
      // level mode: ack coincident with the rising edge is not seen
      drive(1, 2'b00, 2'b11, 0, 0, 0); tick();
      chk("lvl reset flag", 32'(ifl.flag), 1);
      drive(0, 2'b00, 2'b11, 0, 0, 0); tick();
      chk("lvl release flag", 32'(ifl.flag), 0);
      drive(0, 2'b11, 2'b11, 0, 1, 0); tick();
      chk("lvl fire flag", 32'(ifl.flag), 1);
      chk("lvl fire cnt", 32'(ifl.round_cnt), 1);
      for (int i = 0; i < 20; i++) begin
         drive(0, (i < 10) ? 2'b11 : 2'b00, 2'b11, 0, 0, 0);
         tick();
         chk($sformatf("lvl held %0d", i), 32'(ifl.flag), 1);
      end
      drive(0, 2'b11, 2'b11, 0, 1, 0); tick();
      chk("lvl ack flag", 32'(ifl.flag), 0);
      chk("lvl ack busy", 32'(ifl.busy), 1);
      drive(0, 2'b11, 2'b11, 0, 0, 0); tick();
      chk("lvl hold busy", 32'(ifl.busy), 1);
      chk("lvl hold flag", 32'(ifl.flag), 0);
      drive(0, 2'b00, 2'b11, 0, 0, 0); tick();
      chk("lvl idle busy", 32'(ifl.busy), 0);
      drive(0, 2'b11, 2'b11, 0, 0, 0); tick();
      chk("lvl fire2 flag", 32'(ifl.flag), 1);
      drive(0, 2'b11, 2'b11, 0, 1, 1); tick();
      chk("lvl abort flag", 32'(ifl.flag), 0);
      chk("lvl abort busy", 32'(ifl.busy), 0);
      chk("lvl abort cnt", 32'(ifl.round_cnt), 2);
      drive(0, 2'b11, 2'b11, 0, 0, 0); tick();
      chk("lvl refire flag", 32'(ifl.flag), 1);
      chk("lvl refire cnt", 32'(ifl.round_cnt), 3);
      // 2-bit round counter wraps
      drive(1, 2'b00, 2'b11, 0, 0, 0); tick();
      drive(0, 2'b00, 2'b11, 0, 0, 0); tick();
      for (int k = 1; k <= 4; k++) begin
         drive(0, 2'b11, 2'b11, 0, 0, 0); tick();
         chk($sformatf("wrap flag %0d", k), 32'(ifw.flag), 1);
         chk($sformatf("wrap cnt %0d", k), 32'(ifw.round_cnt), 32'(k % 4));
         drive(0, 2'b00, 2'b11, 0, 0, 0); tick(); tick();
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
